// File: rtl/qkv_sched.sv
// qkv_sched: round-robin scheduler sharing one qkv_linear engine among R requesters.
// Ports: clk, rst_n (async, active-low);
//   requests  req_valid[R], req_x[R][N], req_ready[R] (one-hot grant);
//   engine    eng_start, eng_x, eng_done, eng_q/eng_k/eng_v;
//   response  rsp_valid, rsp_ready, rsp_id, rsp_q/rsp_k/rsp_v, rsp_err;
//   status    busy.
// Option: define QKV_SCHED_TIMEOUT_EN to add a WAIT watchdog of TIMEOUT cycles.
module qkv_sched #(
    parameter int N        = 4,
    parameter int WIDTH    = 16,
    parameter int R        = 4,
    parameter int TIMEOUT  = 16,
    localparam int IW      = $clog2(R)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [R-1:0]                          req_valid,
    input  logic signed [R-1:0][N-1:0][WIDTH-1:0] req_x,
    output logic [R-1:0]                          req_ready,
    output logic                                  eng_start,
    output logic signed [N-1:0][WIDTH-1:0]        eng_x,
    input  logic                                  eng_done,
    input  logic signed [N-1:0][WIDTH-1:0]        eng_q,
    input  logic signed [N-1:0][WIDTH-1:0]        eng_k,
    input  logic signed [N-1:0][WIDTH-1:0]        eng_v,
    output logic                                  rsp_valid,
    input  logic                                  rsp_ready,
    output logic [IW-1:0]                         rsp_id,
    output logic signed [N-1:0][WIDTH-1:0]        rsp_q,
    output logic signed [N-1:0][WIDTH-1:0]        rsp_k,
    output logic signed [N-1:0][WIDTH-1:0]        rsp_v,
    output logic                                  rsp_err,
    output logic                                  busy
);

    if (R < 2 || TIMEOUT < 1) begin : g_param_chk
        $error("qkv_sched: need R >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                         state_q, state_d;
    logic [IW-1:0]                  ptr_q, ptr_d;
    logic [IW-1:0]                  id_q, id_d;
    logic signed [N-1:0][WIDTH-1:0] x_q, x_d;
    logic signed [N-1:0][WIDTH-1:0] q_q, q_d;
    logic signed [N-1:0][WIDTH-1:0] k_q, k_d;
    logic signed [N-1:0][WIDTH-1:0] v_q, v_d;
    logic [R-1:0]                   grant;

`ifdef QKV_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    // First valid requester at or above ptr, wrapping modulo R.
    logic          win_vld;
    logic [IW-1:0] win_id;
    logic [IW:0]   idx;

    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = '0;
        for (int k = 0; k < R; k++) begin
            idx = {1'b0, ptr_q} + (IW+1)'(k);
            if (idx >= (IW+1)'(R)) begin
                idx = idx - (IW+1)'(R);
            end
            if (!win_vld && req_valid[idx[IW-1:0]]) begin
                win_vld = 1'b1;
                win_id  = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        x_d     = x_q;
        q_d     = q_q;
        k_d     = k_q;
        v_d     = v_q;
        grant   = '0;
`ifdef QKV_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    grant[win_id] = 1'b1;
                    x_d     = req_x[win_id];
                    id_d    = win_id;
                    ptr_d   = (win_id == IW'(R - 1)) ? '0
                            : win_id + IW'(1);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef QKV_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done on the limit cycle still wins.
                if (eng_done) begin
                    q_d     = eng_q;
                    k_d     = eng_k;
                    v_d     = eng_v;
`ifdef QKV_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_RESP;
                end
`ifdef QKV_SCHED_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    q_d     = '0;
                    k_d     = '0;
                    v_d     = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            x_q     <= '0;
            q_q     <= '0;
            k_q     <= '0;
            v_q     <= '0;
`ifdef QKV_SCHED_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            x_q     <= x_d;
            q_q     <= q_d;
            k_q     <= k_d;
            v_q     <= v_d;
`ifdef QKV_SCHED_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // The grant is combinational, so gate it while reset is held.
    assign req_ready = rst_n ? grant : '0;
    assign eng_start = (state_q == S_ISSUE);
    assign eng_x     = x_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_q     = q_q;
    assign rsp_k     = k_q;
    assign rsp_v     = v_q;
    assign busy      = (state_q != S_IDLE);
`ifdef QKV_SCHED_TIMEOUT_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_qkv_sched.sv
// tb_qkv_sched: randomized self-checking bench for qkv_sched.
// Includes a behavioural qkv_linear stand-in (done 2 cycles after start).
module tb_qkv_sched;

    localparam int N       = 4;
    localparam int WIDTH   = 16;
    localparam int R       = 4;
    localparam int TIMEOUT = 16;
    localparam int IW      = 2;

    typedef logic signed [N-1:0][WIDTH-1:0] vec_t;

    logic                                  clk = 1'b0;
    logic                                  rst_n = 1'b0;
    logic [R-1:0]                          req_valid;
    logic signed [R-1:0][N-1:0][WIDTH-1:0] req_x;
    logic [R-1:0]                          req_ready;
    logic                                  eng_start;
    vec_t                                  eng_x;
    logic                                  eng_done;
    vec_t                                  eng_q, eng_k, eng_v;
    logic                                  rsp_valid;
    logic                                  rsp_ready;
    logic [IW-1:0]                         rsp_id;
    vec_t                                  rsp_q, rsp_k, rsp_v;
    logic                                  rsp_err;
    logic                                  busy;

    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    logic [R-1:0] pend;
    vec_t         pvec [R];
    int           ptr_m;
    logic         eng_en;
    logic         stray;
    logic         pipe, done_r;

    qkv_sched #(
        .N(N), .WIDTH(WIDTH), .R(R), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
        .eng_start(eng_start), .eng_x(eng_x), .eng_done(eng_done),
        .eng_q(eng_q), .eng_k(eng_k), .eng_v(eng_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_q(rsp_q), .rsp_k(rsp_k), .rsp_v(rsp_v),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Projection weights: 0 = Q, 1 = K (identity), 2 = V.
    function automatic int coef(input int sel, input int i, input int j);
        int a [16];
        case (sel)
            0:       a = '{1, 2, 3, 4,  4, 3, 2, 1,  1, -1, 1, -1,  0, 1, 2, 3};
            1:       a = '{1, 0, 0, 0,  0, 1, 0, 0,  0, 0, 1, 0,  0, 0, 0, 1};
            default: a = '{4, 3, 2, 1,  -4, -3, -2, -1,  1, -1, 1, -1,  1, -1, 1, -1};
        endcase
        return a[i*4+j];
    endfunction

    function automatic vec_t mat(input int sel, input vec_t x);
        vec_t y;
        int   acc;
        y = '0;
        for (int i = 0; i < N; i++) begin
            acc = 0;
            for (int j = 0; j < N; j++) begin
                acc += coef(sel, i, j) * int'($signed(x[j]));
            end
            y[i] = acc[WIDTH-1:0];
        end
        return y;
    endfunction

    function automatic vec_t mk(input int a, input int b, input int c, input int d);
        vec_t v;
        v[0] = a[WIDTH-1:0];
        v[1] = b[WIDTH-1:0];
        v[2] = c[WIDTH-1:0];
        v[3] = d[WIDTH-1:0];
        return v;
    endfunction

    function automatic vec_t rvec();
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = WIDTH'($urandom);
        return v;
    endfunction

    function automatic int rr_pick(input logic [R-1:0] p, input int ptr);
        for (int k = 0; k < R; k++) begin
            if (p[(ptr + k) % R]) return (ptr + k) % R;
        end
        return -1;
    endfunction

    function automatic logic [R-1:0] onehot(input int w);
        return (w >= 0) ? (R'(1) << w) : '0;
    endfunction

    // Engine stand-in: start sampled at edge e, done high during the cycle after e+1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe   <= 1'b0;
            done_r <= 1'b0;
        end else begin
            pipe   <= eng_start & eng_en;
            done_r <= pipe;
        end
    end
    assign eng_done = done_r | stray;
    assign eng_q    = mat(0, eng_x);
    assign eng_k    = mat(1, eng_x);
    assign eng_v    = mat(2, eng_x);

    task automatic apply();
        req_valid = pend;
        for (int i = 0; i < R; i++) req_x[i] = pvec[i];
    endtask

    task automatic poke();
        apply();
        #1;
    endtask

    // One clock: grants seen before the edge retire their requests.
    task automatic step();
        logic [R-1:0] g;
        g = req_ready;
        @(posedge clk);
        cyc++;
        #1;
        pend = pend & ~g;
        apply();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        stray = 1'b0;
        eng_en = 1'b1;
        pend = '1;
        for (int i = 0; i < R; i++) pvec[i] = rvec();
        poke();
        repeat (2) @(posedge clk);
        #2;
        tests++;
        if (req_ready !== '0) begin
            fails++; $display("FAIL reset_req_ready got %b want 0", req_ready);
        end
        tests++;
        if ({busy, eng_start, rsp_valid, rsp_err} !== 4'b0) begin
            fails++; $display("FAIL reset_ctrl got %b want 0000",
                              {busy, eng_start, rsp_valid, rsp_err});
        end
        tests++;
        if (eng_x !== '0 || rsp_id !== '0) begin
            fails++; $display("FAIL reset_x_id got %h/%0d want 0/0", eng_x, rsp_id);
        end
        tests++;
        if ({rsp_q, rsp_k, rsp_v} !== '0) begin
            fails++; $display("FAIL reset_rsp_data got %h want 0", {rsp_q, rsp_k, rsp_v});
        end
        pend = '0;
        poke();
        rst_n = 1'b1;
        ptr_m = 0;
        step();
        tests++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            fails++; $display("FAIL reset_release got busy=%b rv=%b want 0", busy, rsp_valid);
        end
    endtask

    task automatic test_single();
        vec_t x, eq, ek, ev;
        int   nrdy, t_start, t_rsp;
        x  = mk(1, 2, 3, 4);
        eq = mk(30, 20, -2, 20);
        ek = mk(1, 2, 3, 4);
        ev = mk(20, -20, -2, -2);
        rsp_ready = 1'b1;
        pvec[1] = x;
        pend = 4'b0010;
        poke();
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++; $display("FAIL single_grant got %b want 0010", req_ready);
        end
        nrdy = 0;
        t_start = -1;
        t_rsp = -1;
        for (int k = 0; k < 12; k++) begin
            if (req_ready[1]) nrdy++;
            if (eng_start && t_start < 0) t_start = k;
            if (k == 1) begin
                tests++;
                if (eng_x !== x) begin
                    fails++; $display("FAIL single_eng_x got %h want %h", eng_x, x);
                end
            end
            if (rsp_valid && t_rsp < 0) begin
                t_rsp = k;
                tests++;
                if (rsp_id !== 2'd1 || rsp_err !== 1'b0) begin
                    fails++; $display("FAIL single_id_err got %0d/%b want 1/0", rsp_id, rsp_err);
                end
                tests++;
                if (rsp_q !== eq || rsp_k !== ek || rsp_v !== ev) begin
                    fails++; $display("FAIL single_data got q=%h k=%h v=%h want q=%h k=%h v=%h",
                                      rsp_q, rsp_k, rsp_v, eq, ek, ev);
                end
            end
            step();
        end
        tests++;
        if (nrdy != 1) begin
            fails++; $display("FAIL single_ready_pulses got %0d want 1", nrdy);
        end
        tests++;
        if (t_start != 1 || t_rsp != 4) begin
            fails++; $display("FAIL single_latency got start=%0d rsp=%0d want 1/4", t_start, t_rsp);
        end
        ptr_m = 2;
    endtask

    task automatic test_round_robin();
        vec_t exp_x [$];
        int   exp_id [$];
        int   last_acc, ngr, nrsp, w, acc_w;
        logic refill;
        vec_t ex;
        int   eid;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        ptr_m = 0;
        last_acc = -1;
        ngr = 0;
        nrsp = 0;
        acc_w = 0;
        refill = 1'b0;
        rsp_ready = 1'b1;
        pend = '1;
        for (int i = 0; i < R; i++) pvec[i] = rvec();
        poke();
        for (int c = 0; c < 80 && nrsp < 8; c++) begin
            if (req_ready != '0) begin
                w = rr_pick(pend, ptr_m);
                tests++;
                if (req_ready !== onehot(w) || w != ngr % R) begin
                    fails++; $display("FAIL rr_grant got %b want %b", req_ready, onehot(ngr % R));
                end
                if (ngr > 0) begin
                    tests++;
                    if (c - last_acc != 5) begin
                        fails++; $display("FAIL rr_spacing got %0d want 5", c - last_acc);
                    end
                end
                last_acc = c;
                exp_id.push_back(w);
                exp_x.push_back(pvec[w]);
                ptr_m = (w + 1) % R;
                ngr++;
                acc_w = w;
                refill = 1'b1;
            end
            if (rsp_valid && exp_id.size() > 0) begin
                eid = exp_id.pop_front();
                ex = exp_x.pop_front();
                nrsp++;
                tests++;
                if (rsp_id !== IW'(eid) || rsp_err !== 1'b0) begin
                    fails++; $display("FAIL rr_id got %0d want %0d", rsp_id, eid);
                end
                tests++;
                if (rsp_q !== mat(0, ex) || rsp_k !== mat(1, ex) || rsp_v !== mat(2, ex)) begin
                    fails++; $display("FAIL rr_data id %0d got q=%h want q=%h", eid, rsp_q, mat(0, ex));
                end
            end
            step();
            if (refill) begin
                pvec[acc_w] = rvec();
                pend[acc_w] = 1'b1;
                poke();
                refill = 1'b0;
            end
        end
        tests++;
        if (nrsp != 8) begin
            fails++; $display("FAIL rr_count got %0d want 8", nrsp);
        end
        pend = '0;
        poke();
        repeat (6) step();
    endtask

    task automatic test_backpressure();
        vec_t xs;
        int   w, w2;
        rsp_ready = 1'b0;
        pend = 4'b1001;
        pvec[0] = rvec();
        pvec[3] = rvec();
        poke();
        w = rr_pick(pend, ptr_m);
        tests++;
        if (req_ready !== onehot(w)) begin
            fails++; $display("FAIL bp_grant got %b want %b", req_ready, onehot(w));
        end
        xs = pvec[w];
        ptr_m = (w + 1) % R;
        step();
        for (int k = 0; k < 10 && !rsp_valid; k++) step();
        tests++;
        if (rsp_valid !== 1'b1) begin
            fails++; $display("FAIL bp_rsp_timeout got %b want 1", rsp_valid);
        end
        for (int k = 0; k < 10; k++) begin
            tests++;
            if (rsp_valid !== 1'b1 || rsp_id !== IW'(w) || rsp_q !== mat(0, xs) ||
                rsp_k !== mat(1, xs) || rsp_v !== mat(2, xs)) begin
                fails++; $display("FAIL bp_hold cyc %0d got rv=%b id=%0d q=%h want 1/%0d/%h",
                                  k, rsp_valid, rsp_id, rsp_q, w, mat(0, xs));
            end
            tests++;
            if (req_ready !== '0) begin
                fails++; $display("FAIL bp_no_grant got %b want 0", req_ready);
            end
            step();
        end
        rsp_ready = 1'b1;
        poke();
        step();
        w2 = rr_pick(pend, ptr_m);
        tests++;
        if (req_ready !== onehot(w2) || w2 < 0) begin
            fails++; $display("FAIL bp_next_grant got %b want %b", req_ready, onehot(w2));
        end
        xs = pvec[w2];
        ptr_m = (w2 + 1) % R;
        step();
        for (int k = 0; k < 12 && !rsp_valid; k++) step();
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== IW'(w2) || rsp_q !== mat(0, xs)) begin
            fails++; $display("FAIL bp_second got rv=%b id=%0d want 1/%0d", rsp_valid, rsp_id, w2);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int   nrsp, w;
        int   qid [$];
        vec_t qx [$];
        vec_t ex;
        int   eid;
        rsp_ready = 1'b1;
        pend = 4'b0100;
        pvec[2] = rvec();
        poke();
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++; $display("FAIL mid_grant got %b want 0100", req_ready);
        end
        step();
        step();
        tests++;
        if (busy !== 1'b1 || eng_start !== 1'b0) begin
            fails++; $display("FAIL mid_in_wait got busy=%b start=%b want 1/0", busy, eng_start);
        end
        rst_n = 1'b0;
        pend = 4'b1100;
        poke();
        tests++;
        if ({req_ready, busy, eng_start, rsp_valid, rsp_err} !== '0 ||
            {eng_x, rsp_q, rsp_k, rsp_v} !== '0 || rsp_id !== '0) begin
            fails++; $display("FAIL mid_reset_outputs got rr=%b busy=%b rv=%b x=%h want 0",
                              req_ready, busy, rsp_valid, eng_x);
        end
        step();
        step();
        pend = '0;
        poke();
        rst_n = 1'b1;
        ptr_m = 0;
        for (int k = 0; k < 6; k++) begin
            tests++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                fails++; $display("FAIL mid_no_rsp got rv=%b busy=%b want 0/0", rsp_valid, busy);
            end
            step();
        end
        pend = 4'b1100;
        pvec[2] = rvec();
        pvec[3] = rvec();
        poke();
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++; $display("FAIL mid_ptr_reset got %b want 0100", req_ready);
        end
        nrsp = 0;
        for (int c = 0; c < 40 && nrsp < 2; c++) begin
            if (req_ready != '0) begin
                w = rr_pick(pend, ptr_m);
                qid.push_back(w);
                qx.push_back(pvec[w]);
                ptr_m = (w + 1) % R;
            end
            if (rsp_valid && qid.size() > 0) begin
                eid = qid.pop_front();
                ex = qx.pop_front();
                tests++;
                if (rsp_id !== IW'(2 + nrsp) || eid != 2 + nrsp || rsp_q !== mat(0, ex)) begin
                    fails++; $display("FAIL mid_after_rsp got id=%0d want %0d", rsp_id, 2 + nrsp);
                end
                nrsp++;
            end
            step();
        end
        tests++;
        if (nrsp != 2) begin
            fails++; $display("FAIL mid_rsp_count got %0d want 2", nrsp);
        end
    endtask

    task automatic test_stray_done();
        pend = '0;
        poke();
        stray = 1'b1;
        step();
        stray = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
                fails++; $display("FAIL stray_done got busy=%b rv=%b want 0/0", busy, rsp_valid);
            end
            step();
        end
    endtask

    task automatic test_random();
        int           qid [$];
        vec_t         qx [$];
        logic         outst, hs, gr;
        logic [R-1:0] exp_g;
        int           acc_c, ntx, w, d;
        outst = 1'b0;
        acc_c = 0;
        ntx = 0;
        for (int c = 0; c < 2000 && ntx < 40; c++) begin
            for (int i = 0; i < R; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    pvec[i] = rvec();
                end
            end
            if ($urandom_range(0, 9) == 0) begin
                d = $urandom_range(0, R - 1);
                pend[d] = 1'b0;
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            poke();
            exp_g = outst ? '0 : onehot(rr_pick(pend, ptr_m));
            tests++;
            if (req_ready !== exp_g) begin
                fails++; $display("FAIL rnd_grant c%0d got %b want %b", c, req_ready, exp_g);
            end
            gr = 1'b0;
            if (exp_g != '0 && req_ready === exp_g) begin
                w = rr_pick(pend, ptr_m);
                qid.push_back(w);
                qx.push_back(pvec[w]);
                ptr_m = (w + 1) % R;
                acc_c = c;
                gr = 1'b1;
            end
            tests++;
            if (rsp_valid !== (outst && (c - acc_c >= 4))) begin
                fails++; $display("FAIL rnd_rsp_valid c%0d got %b want %b",
                                  c, rsp_valid, outst && (c - acc_c >= 4));
            end
            if (outst && qid.size() > 0) begin
                tests++;
                if (eng_x !== qx[0]) begin
                    fails++; $display("FAIL rnd_eng_x got %h want %h", eng_x, qx[0]);
                end
            end
            hs = 1'b0;
            if (rsp_valid && qid.size() > 0) begin
                tests++;
                if (rsp_id !== IW'(qid[0]) || rsp_err !== 1'b0 || rsp_q !== mat(0, qx[0]) ||
                    rsp_k !== mat(1, qx[0]) || rsp_v !== mat(2, qx[0])) begin
                    fails++; $display("FAIL rnd_rsp got id=%0d q=%h want id=%0d q=%h",
                                      rsp_id, rsp_q, qid[0], mat(0, qx[0]));
                end
                if (rsp_ready) begin
                    hs = 1'b1;
                    void'(qid.pop_front());
                    void'(qx.pop_front());
                    ntx++;
                end
            end
            step();
            if (gr) outst = 1'b1;
            if (hs) outst = 1'b0;
        end
        tests++;
        if (ntx < 40) begin
            fails++; $display("FAIL rnd_progress got %0d want 40", ntx);
        end
        pend = '0;
        rsp_ready = 1'b1;
        poke();
        repeat (8) step();
    endtask

`ifdef QKV_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int t;
        eng_en = 1'b0;
        rsp_ready = 1'b1;
        pend = 4'b0010;
        pvec[1] = rvec();
        poke();
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++; $display("FAIL tmo_grant got %b want 0010", req_ready);
        end
        ptr_m = 2;
        t = -1;
        for (int k = 0; k < 40 && t < 0; k++) begin
            if (rsp_valid) t = k;
            else step();
        end
        tests++;
        if (t != TIMEOUT + 2) begin
            fails++; $display("FAIL tmo_latency got %0d want %0d", t, TIMEOUT + 2);
        end
        tests++;
        if (rsp_err !== 1'b1 || rsp_id !== 2'd1 || {rsp_q, rsp_k, rsp_v} !== '0) begin
            fails++; $display("FAIL tmo_rsp got err=%b id=%0d q=%h want 1/1/0", rsp_err, rsp_id, rsp_q);
        end
        step();
        eng_en = 1'b1;
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL tmo_idle got busy=%b want 0", busy);
        end
    endtask
`endif

    initial begin
        req_valid = '0;
        req_x = '0;
        rsp_ready = 1'b0;
        stray = 1'b0;
        eng_en = 1'b1;
        pend = '0;
        ptr_m = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_stray_done();
        test_random();
`ifdef QKV_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
